// File: rtl/string_hw_seq_if.sv
// Handshake and operand bundle for string_hw_seq: the register wrapper is the
// master and drives operands and go; the sequencer answers with busy/done/err/result.
interface string_hw_seq_if #(
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                        go;
    logic [2:0]                  index;
    logic [0:MAX_LEN-1][7:0]     A;
    logic [0:MAX_LEN-1][7:0]     B;
    logic [LEN_W-1:0]            length;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic [0:MAX_LEN-1][7:0]     result;

    modport master (
        output go, index, A, B, length,
        input  busy, done, err, result
    );

    modport slave (
        input  go, index, A, B, length,
        output busy, done, err, result
    );
endinterface

// File: rtl/string_hw_seq.sv
// String sequencer: one character per clock over right-justified strings of up to MAX_LEN chars.
// Optional build macro STRING_HW_EARLY_EXIT_EN ends compare/find at the first decisive character.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | latch operands, clear accumulators
// RUN   | process offset cnt each clock
// DONE  | publish result, hold done until go falls
module string_hw_seq #(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    string_hw_seq_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int W     = 8 * MAX_LEN;

`ifdef STRING_HW_EARLY_EXIT_EN
    localparam bit early_exit = 1'b1;
`else
    localparam bit early_exit = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef logic [0:MAX_LEN-1][7:0] str_t;

    state_t           state;
    str_t             a_q, b_q, acc;
    logic [LEN_W-1:0] len_q, sc, len_in;
    logic [IDX_W-1:0] cnt, pos;
    logic [2:0]       op;
    logic             flag, last;
    logic [7:0]       ch, key;

    function automatic logic [7:0] conv(input logic [2:0] o, input logic [7:0] c);
        logic lc, uc;
        lc = (c >= 8'h61) && (c <= 8'h7a);
        uc = (c >= 8'h41) && (c <= 8'h5a);
        case (o)
            3'd1:    conv = lc ? c - 8'h20 : c;
            3'd2:    conv = uc ? c + 8'h20 : c;
            3'd3:    conv = (lc || uc) ? c ^ 8'h20 : c;
            default: conv = c;
        endcase
    endfunction

    always_comb begin
        len_in = (bus.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.length;
        pos    = IDX_W'(MAX_LEN - int'(len_q) + int'(cnt));
        ch     = a_q[pos];
        key    = b_q[MAX_LEN-1];
        last   = (LEN_W'(cnt) + LEN_W'(1)) == len_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.result <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            len_q      <= '0;
            sc         <= '0;
            cnt        <= '0;
            op         <= '0;
            flag       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                    end
                end
                LOAD: begin
                    a_q        <= bus.A;
                    b_q        <= bus.B;
                    op         <= bus.index;
                    // an illegal index runs with zero length so done keeps the L=0 timing
                    len_q      <= (bus.index == 3'd7) ? '0 : len_in;
                    acc        <= '0;
                    sc         <= '0;
                    cnt        <= '0;
                    flag       <= (bus.index == 3'd0);
                    bus.err    <= 1'b0;
                    bus.result <= '0;
                    state      <= (bus.index != 3'd7 && len_in != '0) ? RUN : DONE;
                end
                RUN: begin
                    if (!bus.go) begin
                        state      <= IDLE;
                        bus.busy   <= 1'b0;
                        bus.result <= '0;
                    end else begin
                        cnt   <= cnt + IDX_W'(1);
                        state <= last ? DONE : RUN;
                        case (op)
                            3'd0: if (ch != b_q[pos]) begin
                                flag <= 1'b0;
                                if (early_exit) state <= DONE;
                            end
                            3'd1, 3'd2, 3'd3: acc[pos] <= conv(op, ch);
                            3'd4: if (ch == key) sc <= sc + LEN_W'(1);
                            3'd5: acc[IDX_W'(MAX_LEN - 1) - cnt] <= ch;
                            3'd6: if (!flag && ch == key) begin
                                flag <= 1'b1;
                                sc   <= LEN_W'(cnt);
                                if (early_exit) state <= DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    if (!bus.go) begin
                        state    <= IDLE;
                        bus.done <= 1'b0;
                        bus.busy <= 1'b0;
                    end else if (!bus.done) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.err  <= (op == 3'd7);
                        case (op)
                            3'd0:    bus.result <= W'(flag);
                            3'd4:    bus.result <= W'(sc);
                            3'd6:    bus.result <= flag ? W'(sc) : '1;
                            3'd7:    bus.result <= '0;
                            default: bus.result <= acc;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_string_hw_seq.sv
// Self-checking bench for string_hw_seq: directed vectors plus randomized operations
// checked against a character-level reference model.
module tb_string_hw_seq;
    localparam int MAX_LEN = 8;

`ifdef STRING_HW_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef logic [0:MAX_LEN-1][7:0] str_t;
    typedef struct {
        int   op;
        str_t a;
        str_t b;
        int   len;
        str_t exp;
        int   lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    string_hw_seq_if #(.MAX_LEN(MAX_LEN)) bus ();
    string_hw_seq #(.MAX_LEN(MAX_LEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] case_ref(input int op, input logic [7:0] c);
        logic lower, upper;
        lower = (c >= "a") && (c <= "z");
        upper = (c >= "A") && (c <= "Z");
        case (op)
            1:       return lower ? c - 8'd32 : c;
            2:       return upper ? c + 8'd32 : c;
            3:       return lower ? c - 8'd32 : (upper ? c + 8'd32 : c);
            default: return c;
        endcase
    endfunction

    function automatic void model(input int op, input str_t a, input str_t b, input int len,
                                  output str_t r, output int lat);
        int L, first, cnt;
        L = (len > MAX_LEN) ? MAX_LEN : len;
        r = '0;
        lat = L + 2;
        first = -1;
        cnt = 0;
        if (op == 7) begin
            lat = 2;
            return;
        end
        for (int k = 0; k < L; k++) begin
            int p;
            p = MAX_LEN - L + k;
            case (op)
                0: if (a[p] != b[p] && first < 0) first = k;
                1, 2, 3: r[p] = case_ref(op, a[p]);
                4: if (a[p] == b[MAX_LEN-1]) cnt++;
                5: r[p] = a[MAX_LEN-1-k];
                6: if (a[p] == b[MAX_LEN-1] && first < 0) first = k;
                default: ;
            endcase
        end
        if (op == 0) begin
            r[MAX_LEN-1] = (first < 0) ? 8'd1 : 8'd0;
            if (EE && first >= 0) lat = first + 3;
        end
        if (op == 4) r[MAX_LEN-1] = 8'(cnt);
        if (op == 6) begin
            if (first < 0) r = '1;
            else begin
                r[MAX_LEN-1] = 8'(first);
                if (EE) lat = first + 3;
            end
        end
    endfunction

    function automatic logic [7:0] rand_ch();
        logic [7:0] edges [8] = '{8'h40, 8'h41, 8'h5a, 8'h5b, 8'h60, 8'h61, 8'h7a, 8'h7b};
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(97, 99));
            1:       return 8'($urandom_range(65, 67));
            2:       return 8'($urandom_range(32, 126));
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    // Drives one operation, scrambles operands after LOAD, and reports what was observed.
    task automatic run_op(input int op, input str_t a, input str_t b, input int len,
                          output str_t res, output logic e, output int lat,
                          output logic timed_out, output logic busy_ok,
                          output logic held_ok, output logic rel_ok);
        @(negedge clk);
        bus.index = 3'(op); bus.A = a; bus.B = b; bus.length = 4'(len); bus.go = 1'b1;
        @(posedge clk);
        lat = 0; timed_out = 1'b1; busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                bus.A = {$urandom, $urandom};
                bus.B = {$urandom, $urandom};
                bus.index = 3'($urandom);
                bus.length = 4'($urandom);
            end
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        res = bus.result;
        e = bus.err;
        held_ok = !bus.busy;
        repeat (3) begin
            @(negedge clk);
            if (!bus.done || bus.result !== res || bus.busy) held_ok = 1'b0;
        end
        bus.go = 1'b0;
        @(negedge clk);
        rel_ok = !bus.done && !bus.busy;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v[$];
        str_t res;
        logic e, to, bok, hok, rok;
        int lat;
        v.push_back('{0, 64'("abcd"), 64'("acca"), 4, 64'd0, EE ? 4 : 6});
        v.push_back('{0, 64'("ab"), 64'("ab"), 2, 64'd1, 4});
        v.push_back('{1, 64'("AbCd!z"), 64'd0, 6, 64'("ABCD!Z"), 8});
        v.push_back('{2, 64'("ABCD"), 64'd0, 4, 64'("abcd"), 6});
        v.push_back('{3, 64'("aB"), 64'd0, 2, 64'("Ab"), 4});
        v.push_back('{4, 64'("banana"), 64'("a"), 6, 64'd3, 8});
        v.push_back('{6, 64'("banana"), 64'("n"), 6, 64'd2, EE ? 5 : 8});
        v.push_back('{6, 64'("banana"), 64'("x"), 6, {64{1'b1}}, 8});
        v.push_back('{5, 64'("abcdefgh"), 64'd0, 8, 64'("hgfedcba"), 10});
        v.push_back('{5, 64'("abcdefgh"), 64'd0, 12, 64'("hgfedcba"), 10});
        v.push_back('{0, 64'("abcdefgh"), 64'("abXdefgh"), 8, 64'd0, EE ? 5 : 10});
        v.push_back('{7, 64'("abcdefgh"), 64'd0, 5, 64'd0, 2});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, v[i].len, res, e, lat, to, bok, hok, rok);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout op %0d no done", i, v[i].op); end
            checks++; if (res !== v[i].exp) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, res, v[i].exp); end
            checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++; if (e !== (v[i].op == 7)) begin errors++; $display("FAIL dir%0d_err got %b exp %b", i, e, v[i].op == 7); end
            checks++; if ({bok, hok, rok} !== 3'b111) begin errors++; $display("FAIL dir%0d_handshake got %b exp 111", i, {bok, hok, rok}); end
        end
    endtask

    task automatic test_random();
        str_t a, b, res, exp;
        logic e, to, bok, hok, rok;
        int op, len, lat, elat;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 7);
            len = $urandom_range(0, 12);
            for (int k = 0; k < MAX_LEN; k++) a[k] = rand_ch();
            b = a;
            b[$urandom_range(0, MAX_LEN - 1)] = rand_ch();
            if ($urandom_range(0, 1) == 1) b[MAX_LEN-1] = a[$urandom_range(0, MAX_LEN - 1)];
            model(op, a, b, len, exp, elat);
            run_op(op, a, b, len, res, e, lat, to, bok, hok, rok);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout op %0d no done", n, op); end
            checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result op %0d len %0d got %h exp %h", n, op, len, res, exp); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency op %0d got %0d exp %0d", n, op, lat, elat); end
            checks++; if (e !== (op == 7)) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", n, e, op == 7); end
            checks++; if ({bok, hok, rok} !== 3'b111) begin errors++; $display("FAIL rnd%0d_handshake got %b exp 111", n, {bok, hok, rok}); end
        end
    endtask

    task automatic test_abort();
        logic seen;
        @(negedge clk);
        bus.index = 3'd5; bus.A = 64'("abcdefgh"); bus.B = '0; bus.length = 4'd8; bus.go = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.go = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done got 1 exp 0"); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL abort_result got %h exp 0", bus.result); end
    endtask

    task automatic test_reset_mid();
        logic got;
        @(negedge clk);
        bus.index = 3'd1; bus.A = 64'("abcdefgh"); bus.length = 4'd8; bus.go = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %b exp 0", bus.busy); end
        bus.go = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.index = 3'd1; bus.A = 64'("abcd"); bus.length = 4'd4; bus.go = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (got !== 1'b1 || bus.result !== 64'("ABCD")) begin errors++; $display("FAIL rst_pre_done got %b/%h exp 1/%h", got, bus.result, 64'("ABCD")); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL rst_done_result got %h exp 0", bus.result); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done_done got %b exp 0", bus.done); end
        bus.go = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.go = 1'b0; bus.index = '0; bus.A = '0; bus.B = '0; bus.length = '0;
        test_reset();
        test_directed();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
